fix_trailer_gen: RTL and testbench
==================================

FIX_TRAILER_GEN -- requirements
Module: fix_trailer_gen

Interface
REQ-001 Parameter SOH, default 8'h01: field delimiter byte emitted to terminate the trailer.
REQ-002 clk  input  1  clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  8  outgoing message byte, already ending in SOH before the checksum field.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_sop  input  1  first byte of a message, qualified by in_valid.
REQ-007 in_eop  input  1  last body byte of a message, qualified by in_valid.
REQ-008 in_ready  output  1  block accepts the input byte this cycle.
REQ-009 out_data  output  8  transmitted byte.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_last  output  1  final trailer byte (SOH), qualified by out_valid.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 checksum_o  output  8  checksum of the last completed message.
REQ-014 err_o  output  1  one-cycle pulse when a byte arrives outside a message.

Function
REQ-015 Handshake: a transfer occurs when valid and ready are both high; out_data, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 Output stage is one register deep; slot_free = !out_valid || out_ready.
REQ-017 States: IDLE, BODY, T1, T0, TEQ, D2, D1, D0, TSOH.
REQ-018 in_ready = slot_free in IDLE and BODY; 0 in all trailer states.
REQ-019 IDLE, accepted byte with in_sop: load output register, sum <= in_data, go to BODY (or T1 if in_eop also high).
REQ-020 IDLE, accepted byte without in_sop: discard, no output, pulse err_o next cycle, stay IDLE.
REQ-021 BODY, accepted byte: load output register, sum <= sum + in_data mod 256 (8-bit wrap); in_sop ignored; with in_eop go to T1.
REQ-022 On eop acceptance, checksum_o <= final sum (including the eop byte); unchanged otherwise.
REQ-023 Each trailer state, when slot_free, loads one byte and advances: T1 '1' (8'h31), T0 '0' (8'h30), TEQ '=' (8'h3D), D2 hundreds digit, D1 tens, D0 units, TSOH SOH with out_last=1, then IDLE.
REQ-024 Digits: ASCII 8'h30 + decimal digit of checksum_o, always three digits with leading zeros (0 -> "000", 255 -> "255").
REQ-025 Latency: first byte appears on out_data the cycle after acceptance; with out_ready held high, trailer occupies 7 consecutive cycles after the eop byte.
REQ-026 New message may be accepted in IDLE the cycle after TSOH loads.

Reset
REQ-027 Under rst: state IDLE, out_valid=0, out_data=0, out_last=0, checksum_o=0, sum=0, err_o=0.
REQ-028 Reset mid-message or mid-trailer drops the partial message; no further trailer bytes are emitted.

Structure
REQ-029 Shared package fix_pkg holds the state enum, SOH default, and ASCII constants for '0', '1', '='.
REQ-030 One sub-module fix_int2ascii: combinational 8-bit binary to three ASCII decimal digits, no dividers (compare/subtract).

Verification
REQ-031 Single byte 8'h41 with sop+eop, out_ready=1 -> out: 41,31,30,3D,30,36,35,01; out_last on 01; checksum_o=65.
REQ-032 Bytes FF (sop), 02 (eop) -> sum wraps to 1; trailer digits 30,30,31.
REQ-033 Single byte FF -> digits 32,35,35; bytes 80,80 -> checksum 0, digits 30,30,30.
REQ-034 out_ready low 3 cycles while D1 digit held -> out_data/out_valid stable, in_ready=0, no byte lost or duplicated.
REQ-035 Byte 8'h38 in IDLE without sop -> no output, err_o pulse of one cycle, next sop message unaffected.
REQ-036 rst asserted during TEQ -> next cycle out_valid=0, state IDLE, following message emits correct full trailer.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared definitions for the FIX trailer generator: FSM states and the
// fixed ASCII bytes of the "10=" checksum tag.
package fix_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BODY,
        S_T1,
        S_T0,
        S_TEQ,
        S_D2,
        S_D1,
        S_D0,
        S_TSOH
    } state_t;

    localparam logic [7:0] SOH_DEFAULT = 8'h01;
    localparam logic [7:0] ASC_0       = 8'h30;
    localparam logic [7:0] ASC_1       = 8'h31;
    localparam logic [7:0] ASC_EQ      = 8'h3D;

endpackage

// File: rtl/fix_int2ascii.sv
// Combinational 8-bit binary to three ASCII decimal digits using
// compare/subtract steps only.
module fix_int2ascii
    import fix_pkg::*;
(
    input  logic [7:0] i_bin,
    output logic [7:0] o_d2,
    output logic [7:0] o_d1,
    output logic [7:0] o_d0
);

    logic [1:0] w_hund;
    logic [3:0] w_tens;
    logic [7:0] w_rem;
    logic [7:0] w_units;

    always_comb begin
        w_hund = 2'd0;
        w_rem  = i_bin;
        if (i_bin >= 8'd200) begin
            w_hund = 2'd2;
            w_rem  = i_bin - 8'd200;
        end else if (i_bin >= 8'd100) begin
            w_hund = 2'd1;
            w_rem  = i_bin - 8'd100;
        end

        // Remainder is below 100, so at most nine tens can be peeled off.
        w_tens  = 4'd0;
        w_units = w_rem;
        for (int k = 0; k < 9; k++) begin
            if (w_units >= 8'd10) begin
                w_units = w_units - 8'd10;
                w_tens  = w_tens + 4'd1;
            end
        end

        o_d2 = ASC_0 + {6'd0, w_hund};
        o_d1 = ASC_0 + {4'd0, w_tens};
        o_d0 = ASC_0 + w_units;
    end

endmodule

// File: rtl/fix_trailer_gen.sv
// Passes a FIX message body through and appends the "10=NNN<SOH>" checksum
// trailer computed as the mod-256 byte sum of the body.
module fix_trailer_gen
    import fix_pkg::*;
#(
    parameter logic [7:0] SOH = SOH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] checksum_o,
    output logic       err_o
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sum;
    logic [7:0] r_checksum;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_err;

    logic       w_slot_free;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_load;
    logic       w_last;
    logic [7:0] w_byte;
    logic [7:0] w_sum_add;
    logic [7:0] w_d2;
    logic [7:0] w_d1;
    logic [7:0] w_d0;

    fix_int2ascii u_int2ascii (
        .i_bin (r_checksum),
        .o_d2  (w_d2),
        .o_d1  (w_d1),
        .o_d0  (w_d0)
    );

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_sum_add   = r_sum + in_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_byte      = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_in_ready = w_slot_free;
                if (w_accept && in_sop) begin
                    w_load      = 1'b1;
                    w_byte      = in_data;
                    w_state_nxt = in_eop ? S_T1 : S_BODY;
                end
            end
            S_BODY: begin
                w_in_ready = w_slot_free;
                if (w_accept) begin
                    w_load = 1'b1;
                    w_byte = in_data;
                    if (in_eop) w_state_nxt = S_T1;
                end
            end
            S_T1:   if (w_slot_free) begin w_load = 1'b1; w_byte = ASC_1;  w_state_nxt = S_T0;  end
            S_T0:   if (w_slot_free) begin w_load = 1'b1; w_byte = ASC_0;  w_state_nxt = S_TEQ; end
            S_TEQ:  if (w_slot_free) begin w_load = 1'b1; w_byte = ASC_EQ; w_state_nxt = S_D2;  end
            S_D2:   if (w_slot_free) begin w_load = 1'b1; w_byte = w_d2;   w_state_nxt = S_D1;  end
            S_D1:   if (w_slot_free) begin w_load = 1'b1; w_byte = w_d1;   w_state_nxt = S_D0;  end
            S_D0:   if (w_slot_free) begin w_load = 1'b1; w_byte = w_d0;   w_state_nxt = S_TSOH; end
            S_TSOH: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = SOH;
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= 8'h00;
            r_checksum  <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && (r_state == S_IDLE) && !in_sop;
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    if (in_sop) begin
                        r_sum <= in_data;
                        if (in_eop) r_checksum <= in_data;
                    end
                end else begin
                    r_sum <= w_sum_add;
                    if (in_eop) r_checksum <= w_sum_add;
                end
            end
            // Output register only changes when its current content has left.
            if (w_slot_free) begin
                r_out_valid <= w_load;
                r_out_last  <= w_last;
                if (w_load) r_out_data <= w_byte;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign checksum_o = r_checksum;
    assign err_o      = r_err;

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Directed bench for fix_trailer_gen: table of messages with hand-computed
// trailers, plus backpressure, stray-byte and mid-trailer reset sequences.
module tb_fix_trailer_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] checksum_o;
    logic       err_o;

    always #5 clk = ~clk;

    fix_trailer_gen #(.SOH(8'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .checksum_o (checksum_o),
        .err_o      (err_o)
    );

    typedef struct {
        int             n;
        logic [3:0][7:0] b;
        logic [7:0]     cks;
        logic [7:0]     d2;
        logic [7:0]     d1;
        logic [7:0]     d0;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cks,
                                input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
        vec_t v;
        v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.cks = cks; v.d2 = d2; v.d1 = d1; v.d0 = d0;
        return v;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Entered and left just after a rising edge.
    task automatic send_msg(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            int g;
            in_valid = 1'b1;
            in_data  = v.b[i];
            in_sop   = (i == 0);
            in_eop   = (i == v.n - 1);
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) chk("send_in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_bytes(input int want, input string tag);
        int g;
        g = 0;
        while (q_data.size() < want && g < 80) begin
            @(posedge clk); #1;
            g++;
        end
        if (q_data.size() < want) chk({tag, "_timeout"}, 32'(q_data.size()), 32'(want));
    endtask

    task automatic check_seq(input vec_t v, input string tag, input bit do_lat);
        logic [7:0] e[11];
        int ne;
        ne = v.n + 7;
        for (int i = 0; i < v.n; i++) e[i] = v.b[i];
        e[v.n]   = 8'h31;
        e[v.n+1] = 8'h30;
        e[v.n+2] = 8'h3D;
        e[v.n+3] = v.d2;
        e[v.n+4] = v.d1;
        e[v.n+5] = v.d0;
        e[v.n+6] = 8'h01;
        chk({tag, "_count"}, 32'(q_data.size()), 32'(ne));
        for (int i = 0; i < ne; i++) begin
            if (i < q_data.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(q_data[i]), 32'(e[i]));
                chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == ne - 1));
            end
        end
        chk({tag, "_checksum"}, 32'(checksum_o), 32'(v.cks));
        chk({tag, "_idle_after"}, 32'(out_valid), 32'd0);
        if (do_lat && q_data.size() == ne)
            chk({tag, "_trailer_cycles"}, 32'(q_cyc[ne-1] - q_cyc[v.n-1]), 32'd7);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_q();
        send_msg(v);
        wait_bytes(v.n + 7, tag);
        check_seq(v, tag, 1'b1);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int nrec;

        vecs[0] = mk(1, 8'h41, 8'h00, 8'h00, 8'h00, 8'd65,  8'h30, 8'h36, 8'h35);
        vecs[1] = mk(2, 8'hFF, 8'h02, 8'h00, 8'h00, 8'd1,   8'h30, 8'h30, 8'h31);
        vecs[2] = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd255, 8'h32, 8'h35, 8'h35);
        vecs[3] = mk(2, 8'h80, 8'h80, 8'h00, 8'h00, 8'd0,   8'h30, 8'h30, 8'h30);
        vecs[4] = mk(4, 8'h10, 8'h20, 8'h30, 8'h46, 8'd166, 8'h31, 8'h36, 8'h36);
        vecs[5] = mk(1, 8'h64, 8'h00, 8'h00, 8'h00, 8'd100, 8'h31, 8'h30, 8'h30);
        vecs[6] = mk(1, 8'hC7, 8'h00, 8'h00, 8'h00, 8'd199, 8'h31, 8'h39, 8'h39);
        vecs[7] = mk(1, 8'hC8, 8'h00, 8'h00, 8'h00, 8'd200, 8'h32, 8'h30, 8'h30);
        vecs[8] = mk(3, 8'h05, 8'h03, 8'h02, 8'h00, 8'd10,  8'h30, 8'h31, 8'h30);

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_checksum", 32'(checksum_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure while the tens digit sits in the output register.
        clear_q();
        send_msg(vecs[0]);
        g = 0;
        while (!(out_valid && out_data == 8'h36) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        out_ready = 1'b0;
        chk("stall_reached", 32'(out_data), 32'h36);
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", 32'(out_data), 32'h36);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_bytes(8, "stall");
        check_seq(vecs[0], "stall", 1'b0);

        // Stray byte outside a message.
        clear_q();
        in_valid = 1'b1;
        in_data  = 8'h38;
        @(negedge clk);
        chk("stray_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("stray_err_pulse", 32'(err_o), 32'd1);
        chk("stray_no_output", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("stray_err_clear", 32'(err_o), 32'd0);
        chk("stray_no_bytes", 32'(q_data.size()), 32'd0);
        run_vec(vecs[0], "after_stray");

        // Reset while the FSM sits in TEQ (T0 byte on the output).
        clear_q();
        send_msg(vecs[0]);
        g = 0;
        while (!(out_valid && out_data == 8'h31) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        chk("pre_rst_t0_byte", 32'(out_data), 32'h30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        nrec = q_data.size();
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_more_bytes", 32'(q_data.size()), 32'(nrec));
        chk("midrst_still_idle", 32'(out_valid), 32'd0);
        run_vec(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
